fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter.sv | 135 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for the shared FIFO write port.
// Each owner gets a burst of up to BURST_LEN beats, then the grant rotates.
// FIFO full stalls the owner without losing data or ownership.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t             state_reg, state_next;
    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic [ID_W-1:0]    grant_id_reg, grant_id_next;
    logic [ID_W-1:0]    last_reg, last_next;
    logic [CNT_W-1:0]   beat_reg, beat_next;

    logic [DATA_WIDTH-1:0] data_slice [NUM_REQ];
    logic                  pick_found;
    logic [ID_W-1:0]       pick_id;
    logic [ID_W-1:0]       cand;
    logic                  owner_valid;
    logic                  xfer;
    logic [CNT_W-1:0]      beat_inc;
    logic                  in_grant;

    // Per-requester data slices and ready bits; ready is gated by state so it
    // drops as soon as reset clears the state register.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign data_slice[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign req_ready[gi]  = in_grant && (grant_id_reg == ID_W'(gi)) && !fifo_full;
        end
    endgenerate

    assign in_grant    = (state_reg == GRANT);
    assign owner_valid = req_valid[grant_id_reg];
    assign xfer        = in_grant && owner_valid && !fifo_full;
    assign beat_inc    = beat_reg + 1'b1;
    assign grant       = grant_reg;
    assign grant_id    = grant_id_reg;

    // State register: all arbitration state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            grant_id_reg <= '0;
            last_reg     <= ID_W'(NUM_REQ - 1);
            beat_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            grant_id_reg <= grant_id_next;
            last_reg     <= last_next;
            beat_reg     <= beat_next;
        end
    end

    // Round-robin search starting just after the last owner; the pointer
    // wraps by explicit compare so non-power-of-two NUM_REQ works.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = last_reg;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (cand == ID_W'(NUM_REQ - 1)) cand = '0;
            else                            cand = cand + 1'b1;
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    // Next-state logic: grant in IDLE, count beats and release in GRANT.
    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        grant_id_next = grant_id_reg;
        last_next     = last_reg;
        beat_next     = beat_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    state_next    = GRANT;
                    grant_next    = NUM_REQ'(1) << pick_id;
                    grant_id_next = pick_id;
                    beat_next     = '0;
                end
            end
            GRANT: begin
                if (!owner_valid) begin
                    state_next = IDLE;
                    grant_next = '0;
                    last_next  = grant_id_reg;
                end else if (xfer) begin
                    beat_next = beat_inc;
                    if (beat_inc == CNT_W'(BURST_LEN)) begin
                        state_next = IDLE;
                        grant_next = '0;
                        last_next  = grant_id_reg;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FIFO write outputs: zero-latency path from the owner, gated by state.
    always_comb begin
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        if (in_grant) begin
            fifo_wr_en   = xfer;
            fifo_wr_data = data_slice[grant_id_reg];
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: producer models, a cycle-level reference of the
// arbitration rules, directed scenarios and a randomized soak.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int BL = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            fifo_full;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_wr_data;
    logic [NR-1:0]   grant;
    logic [1:0]      grant_id;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data), .grant(grant), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // producers
    bit          prod_en   [NR];
    int          prod_left [NR];
    logic [7:0]  prod_val  [NR];
    bit          rand_valid = 0;
    bit          rand_full  = 0;

    // logs
    logic [7:0] wr_log[$];
    int         wr_cyc[$];
    int         gid_log[$];
    int         burst_log[$];
    logic [NR-1:0] prev_grant = '0;

    // reference: owner < 0 means no one holds the grant
    int m_owner = -1;
    int m_beats = 0;
    int m_last  = NR - 1;
    int m_gid   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the reference, then advance reference and producers.
    always @(negedge clk) begin
        logic [NR-1:0] e_ready, e_grant;
        logic          e_wr;
        logic [DW-1:0] e_data;
        bit            found;
        int            idx;
        cyc++;
        if (!rst_n) begin
            m_owner = -1; m_beats = 0; m_last = NR - 1; m_gid = 0;
            check("rst_grant", grant, 0);
            check("rst_gid", grant_id, 0);
            check("rst_ready", req_ready, 0);
            check("rst_wr_en", fifo_wr_en, 0);
            check("rst_wr_data", fifo_wr_data, 0);
        end else begin
            e_ready = '0; e_grant = '0; e_wr = 1'b0; e_data = '0;
            if (m_owner >= 0) begin
                e_grant = NR'(1) << m_owner;
                if (!fifo_full) e_ready = NR'(1) << m_owner;
                e_wr   = req_valid[m_owner] && !fifo_full;
                e_data = req_data[m_owner*DW +: DW];
            end
            check("grant", grant, e_grant);
            check("grant_id", grant_id, m_gid);
            check("req_ready", req_ready, e_ready);
            check("wr_en", fifo_wr_en, e_wr);
            check("wr_data", fifo_wr_data, e_data);

            if (grant != 0 && prev_grant == 0) begin
                gid_log.push_back(int'(grant_id));
                burst_log.push_back(0);
            end
            if (fifo_wr_en) begin
                wr_log.push_back(fifo_wr_data);
                wr_cyc.push_back(cyc);
                if (burst_log.size() > 0) burst_log[burst_log.size()-1]++;
                $display("write cyc=%0d gid=%0d data=%02h", cyc, grant_id, fifo_wr_data);
            end
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    prod_val[i]++;
                    prod_left[i]--;
                end
            end

            if (m_owner < 0) begin
                found = 0;
                for (int k = 1; k <= NR; k++) begin
                    idx = (m_last + k) % NR;
                    if (!found && req_valid[idx]) begin
                        found = 1; m_owner = idx; m_gid = idx; m_beats = 0;
                    end
                end
            end else if (!req_valid[m_owner]) begin
                m_last = m_owner; m_owner = -1;
            end else if (!fifo_full) begin
                m_beats++;
                if (m_beats == BL) begin
                    m_last = m_owner; m_owner = -1;
                end
            end
        end
        prev_grant = grant;
    end

    // Input driver, updates well after the active edge.
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < NR; i++) begin
            logic v;
            v = prod_en[i] && (prod_left[i] > 0);
            if (rand_valid && $urandom_range(0, 3) == 0) v = 1'b0;
            req_valid[i] = v;
            req_data[i*DW +: DW] = prod_val[i];
        end
        if (rand_full) fifo_full = ($urandom_range(0, 4) == 0);
    end

    task automatic clear_logs();
        wr_log.delete(); wr_cyc.delete(); gid_log.delete(); burst_log.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; fifo_full = 1'b0; rand_valid = 0; rand_full = 0;
        for (int i = 0; i < NR; i++) begin prod_en[i] = 0; prod_left[i] = 0; end
        clear_logs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic setp(input int i, input int left, input logic [7:0] base);
        prod_en[i] = 1; prod_left[i] = left; prod_val[i] = base;
    endtask

    task automatic wait_writes(input int n, input int budget);
        int b = 0;
        while (wr_log.size() < n && b < budget) begin
            @(negedge clk); #1; b++;
        end
        check("write_timeout", wr_log.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required $finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = '0; req_data = '0; fifo_full = 1'b0;
        for (int i = 0; i < NR; i++) begin prod_en[i] = 0; prod_left[i] = 0; prod_val[i] = '0; end

        // reset, nobody valid: everything quiet for 10 cycles
        do_reset();
        repeat (10) begin
            @(negedge clk); #1;
            check("t1_grant", grant, 0);
            check("t1_wr_en", fifo_wr_en, 0);
            check("t1_ready", req_ready, 0);
        end
        check("t1_writes", wr_log.size(), 0);

        // single requester 2, 8 beats: two bursts with one bubble
        do_reset();
        setp(2, 8, 8'hA0);
        wait_writes(8, 60);
        if (wr_log.size() == 8) begin
            for (int k = 0; k < 8; k++) check("t2_data", wr_log[k], 32'hA0 + k);
            check("t2_burst1_span", wr_cyc[3] - wr_cyc[0], 3);
            check("t2_bubble", wr_cyc[4] - wr_cyc[3], 2);
            check("t2_burst2_span", wr_cyc[7] - wr_cyc[4], 3);
        end
        check("t2_grants", gid_log.size(), 2);
        if (gid_log.size() == 2) begin
            check("t2_gid0", gid_log[0], 2);
            check("t2_gid1", gid_log[1], 2);
        end

        // all four continuously valid: order 0,1,2,3,0, four beats each
        do_reset();
        for (int i = 0; i < NR; i++) setp(i, 100, 8'(i * 16));
        repeat (26) begin @(negedge clk); #1; end
        if (gid_log.size() >= 5) begin
            check("t3_order0", gid_log[0], 0);
            check("t3_order1", gid_log[1], 1);
            check("t3_order2", gid_log[2], 2);
            check("t3_order3", gid_log[3], 3);
            check("t3_order4", gid_log[4], 0);
            for (int k = 0; k < 4; k++) check("t3_burst_len", burst_log[k], 4);
        end else check("t3_grant_count", gid_log.size(), 5);
        if (wr_log.size() >= 5) begin
            check("t3_first", wr_log[0], 32'h00);
            check("t3_second_owner", wr_log[4], 32'h10);
        end

        // FIFO full for 5 cycles after beat 2 of requester 1
        do_reset();
        setp(1, 4, 8'h10);
        wait_writes(2, 20);
        @(posedge clk); #1 fifo_full = 1'b1;
        repeat (5) begin
            @(negedge clk); #1;
            check("t4_wr_en_stall", fifo_wr_en, 0);
            check("t4_ready_stall", req_ready, 0);
            check("t4_grant_kept", grant, 4'b0010);
        end
        @(posedge clk); #1 fifo_full = 1'b0;
        wait_writes(4, 20);
        repeat (5) begin @(negedge clk); #1; end
        check("t4_count", wr_log.size(), 4);
        if (wr_log.size() == 4)
            for (int k = 0; k < 4; k++) check("t4_data", wr_log[k], 32'h10 + k);

        // requester 3 drops after one beat, requester 0 then wins by wrap
        do_reset();
        setp(3, 1, 8'h30);
        begin
            int b = 0;
            while (grant != 4'b1000 && b < 10) begin @(negedge clk); #1; b++; end
            check("t5_grant3", grant, 4'b1000);
        end
        @(posedge clk); #1 setp(0, 2, 8'h50);
        wait_writes(3, 30);
        if (wr_log.size() == 3) begin
            check("t5_d0", wr_log[0], 32'h30);
            check("t5_d1", wr_log[1], 32'h50);
            check("t5_d2", wr_log[2], 32'h51);
        end
        check("t5_grants", gid_log.size(), 2);
        if (gid_log.size() == 2) begin
            check("t5_gid0", gid_log[0], 3);
            check("t5_gid1", gid_log[1], 0);
        end

        // reset mid-burst: outputs drop at once, requester 0 wins afterwards
        do_reset();
        setp(1, 100, 8'h60);
        wait_writes(2, 20);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check("t6_wr_en_async", fifo_wr_en, 0);
        check("t6_grant_async", grant, 0);
        check("t6_ready_async", req_ready, 0);
        setp(0, 3, 8'h70);
        clear_logs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        begin
            int b = 0;
            while (gid_log.size() < 1 && b < 10) begin @(negedge clk); #1; b++; end
        end
        check("t6_grants", gid_log.size() >= 1, 1);
        if (gid_log.size() >= 1) check("t6_first_gid", gid_log[0], 0);
        if (wr_log.size() >= 1) check("t6_first_data", wr_log[0], 32'h70);

        // randomized soak: random valid drops and random fifo_full
        do_reset();
        for (int i = 0; i < NR; i++) setp(i, 100000, 8'($urandom));
        rand_valid = 1; rand_full = 1;
        repeat (2000) @(negedge clk);
        #1;
        rand_valid = 0; rand_full = 0;
        check("t7_activity", wr_log.size() > 200, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
